// File: rtl/ctx_mode_decide_p.sv
// Context/mode stage of the LOCO-I encoder: gradients, MED prediction and run detection.
// Optional macro NEAR_LOSSLESS_EN enables the near-lossless match tolerance NEAR.
module ctx_mode_decide_p #(
  parameter int BPP   = 8,
  parameter int RUN_W = 10,
  parameter int NEAR  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             END_LINE,
  input  logic [BPP-1:0]   Ix_in,
  input  logic [BPP-1:0]   a,
  input  logic [BPP-1:0]   b,
  input  logic [BPP-1:0]   c,
  input  logic [BPP-1:0]   d,
  output logic [BPP:0]     D1,
  output logic [BPP:0]     D2,
  output logic [BPP:0]     D3,
  output logic [1:0]       mode,
  output logic [BPP:0]     Px,
  output logic [BPP:0]     Ix_out,
  output logic [BPP:0]     Ra,
  output logic [BPP:0]     Rb,
  output logic [RUN_W-1:0] Runcnt,
  output logic             en_out
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_REGULAR = 2'd0;
  localparam logic [1:0] MODE_RUN     = 2'd1;
  localparam logic [1:0] MODE_EOL     = 2'd2;
  localparam logic [1:0] MODE_INTR    = 2'd3;

  // Out-of-range tolerance leaves an empty, named block as a marker for reviewers.
  if (NEAR < 0 || NEAR > 15) begin : g_near_out_of_range
  end

  function automatic logic match(input logic [BPP-1:0] x, input logic [BPP-1:0] y);
`ifdef NEAR_LOSSLESS_EN
    logic [BPP:0] mag;
    mag = (x >= y) ? ({1'b0, x} - {1'b0, y}) : ({1'b0, y} - {1'b0, x});
    return int'(mag) <= NEAR;
`else
    return x == y;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [1:0]       mode_d;
  logic [RUN_W-1:0] runcnt_d;
  logic             en_out_d;
  logic             flat, hit;
  logic [RUN_W-1:0] run_inc;
  logic [BPP-1:0]   ab_max, ab_min;
  logic [BPP+1:0]   med_sum;
  logic [BPP-1:0]   px_d;

  assign flat    = match(d, c) & match(b, d) & match(d, a);
  assign hit     = match(Ix_in, a);
  assign run_inc = run_q + 1'b1;

  // MED predictor; the sum is wide enough that a+b-c never wraps before truncation.
  assign ab_max  = (a > b) ? a : b;
  assign ab_min  = (a > b) ? b : a;
  assign med_sum = {2'b00, a} + {2'b00, b} - {2'b00, c};
  always_comb begin
    if (c >= ab_max)      px_d = ab_min;
    else if (c <= ab_min) px_d = ab_max;
    else                  px_d = med_sum[BPP-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    run_d   = run_q;
    if (en) begin
      unique case (state_q)
        IDLE: if (flat && hit && !END_LINE) begin
          state_d = RUN;
          run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
        end
        RUN: begin
          if (!hit || END_LINE) begin
            state_d = IDLE;
            run_d   = '0;
          end else if (run_inc == RUN_MAX) begin
            run_d   = '0;
          end else begin
            run_d   = run_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d   = mode;
    runcnt_d = Runcnt;
    en_out_d = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          en_out_d = 1'b1;
          if (!flat) begin
            mode_d   = MODE_REGULAR;
            runcnt_d = '0;
          end else if (!hit) begin
            mode_d   = MODE_INTR;
            runcnt_d = '0;
          end else if (END_LINE) begin
            mode_d   = MODE_EOL;
            runcnt_d = {{(RUN_W-1){1'b0}}, 1'b1};
          end else begin
            mode_d   = MODE_RUN;
            en_out_d = 1'b0;
          end
        end
        RUN: begin
          if (!hit) begin
            // Interrupting pixel is not part of the run; it travels on Ix_out.
            mode_d   = MODE_INTR;
            runcnt_d = run_q;
            en_out_d = 1'b1;
          end else if (END_LINE) begin
            mode_d   = MODE_EOL;
            runcnt_d = run_inc;
            en_out_d = 1'b1;
          end else if (run_inc == RUN_MAX) begin
            mode_d   = MODE_RUN;
            runcnt_d = RUN_MAX;
            en_out_d = 1'b1;
          end else begin
            mode_d   = MODE_RUN;
          end
        end
        default: en_out_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      D1 <= '0; D2 <= '0; D3 <= '0; Px <= '0;
      Ix_out <= '0; Ra <= '0; Rb <= '0;
      mode <= MODE_REGULAR; Runcnt <= '0; en_out <= 1'b0;
    end else begin
      mode   <= mode_d;
      Runcnt <= runcnt_d;
      en_out <= en_out_d;
      if (en) begin
        D1     <= {1'b0, d} - {1'b0, b};
        D2     <= {1'b0, b} - {1'b0, c};
        D3     <= {1'b0, c} - {1'b0, a};
        Px     <= {1'b0, px_d};
        Ix_out <= {1'b0, Ix_in};
        Ra     <= {1'b0, a};
        Rb     <= {1'b0, b};
      end else begin
        D1 <= '0; D2 <= '0; D3 <= '0; Px <= '0;
        Ix_out <= '0; Ra <= '0; Rb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ctx_mode_decide_p.sv
// Directed-vector bench for ctx_mode_decide_p (BPP=8, RUN_W=4, NEAR=0).
module tb_ctx_mode_decide_p;

  localparam int BPP   = 8;
  localparam int RUN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             END_LINE;
  logic [BPP-1:0]   Ix_in, a, b, c, d;
  logic [BPP:0]     D1, D2, D3, Px, Ix_out, Ra, Rb;
  logic [1:0]       mode;
  logic [RUN_W-1:0] Runcnt;
  logic             en_out;

  int total = 0;
  int bad   = 0;

  ctx_mode_decide_p #(.BPP(BPP), .RUN_W(RUN_W), .NEAR(0)) dut (
    .clk(clk), .reset(reset), .en(en), .END_LINE(END_LINE),
    .Ix_in(Ix_in), .a(a), .b(b), .c(c), .d(d),
    .D1(D1), .D2(D2), .D3(D3), .mode(mode), .Px(Px),
    .Ix_out(Ix_out), .Ra(Ra), .Rb(Rb), .Runcnt(Runcnt), .en_out(en_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int pa, input int pb, input int pc, input int pd,
                     input int ix, input logic eol);
    a = pa[BPP-1:0]; b = pb[BPP-1:0]; c = pc[BPP-1:0]; d = pd[BPP-1:0];
    Ix_in = ix[BPP-1:0]; END_LINE = eol; en = 1'b1;
    step();
  endtask

  task automatic idle();
    en = 1'b0; END_LINE = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; END_LINE = 1'b0;
    Ix_in = '0; a = '0; b = '0; c = '0; d = '0;
    step(); step();
    check("rst_en_out", en_out, 0);
    check("rst_mode",   mode,   0);
    check("rst_runcnt", Runcnt, 0);
    check("rst_px",     Px,     0);
    check("rst_d1",     D1,     0);
    reset = 1'b1;

    // Regular pixel, hand-computed gradients and MED.
    pix(10, 20, 5, 30, 12, 0);
    check("t1_mode",   mode,   0);
    check("t1_px",     Px,     20);
    check("t1_d1",     D1,     10);
    check("t1_d2",     D2,     15);
    check("t1_d3",     D3,     'h1FB);
    check("t1_en_out", en_out, 1);
    check("t1_ix_out", Ix_out, 12);
    check("t1_ra",     Ra,     10);
    check("t1_rb",     Rb,     20);
    idle();
    check("gap_en_out", en_out, 0);
    check("gap_px",     Px,     0);
    check("gap_ra",     Ra,     0);

    // Run of 4 interrupted by 51, with an idle gap mid-run.
    for (int i = 0; i < 4; i++) begin
      pix(50, 50, 50, 50, 50, 0);
      check($sformatf("t2_run_en_out%0d", i), en_out, 0);
      check($sformatf("t2_run_mode%0d", i),   mode,   1);
      if (i == 1) idle();
    end
    pix(50, 50, 50, 50, 51, 0);
    check("t2_mode",   mode,   3);
    check("t2_runcnt", Runcnt, 4);
    check("t2_ix_out", Ix_out, 51);
    check("t2_en_out", en_out, 1);
    idle();
    check("t2_hold_mode",   mode,   3);
    check("t2_hold_runcnt", Runcnt, 4);
    check("t2_hold_en_out", en_out, 0);

    // Run ended by END_LINE on the 3rd pixel, then confirm IDLE.
    pix(50, 50, 50, 50, 50, 0);
    pix(50, 50, 50, 50, 50, 0);
    pix(50, 50, 50, 50, 50, 1);
    check("t3_mode",   mode,   2);
    check("t3_runcnt", Runcnt, 3);
    check("t3_en_out", en_out, 1);
    pix(10, 20, 5, 30, 12, 0);
    check("t3_idle_mode", mode, 0);
    pix(50, 50, 50, 50, 50, 1);
    check("t3_single_mode",   mode,   2);
    check("t3_single_runcnt", Runcnt, 1);
    pix(50, 50, 50, 50, 7, 0);
    check("t3_flat_miss_mode",   mode,   3);
    check("t3_flat_miss_runcnt", Runcnt, 0);

    // Saturation flush at RUN_MAX=15, then interruption after 5 more.
    for (int i = 1; i <= 20; i++) begin
      pix(50, 50, 50, 50, 50, 0);
      if (i == 14) check("t4_p14_en_out", en_out, 0);
      if (i == 15) begin
        check("t4_flush_mode",   mode,   1);
        check("t4_flush_runcnt", Runcnt, 15);
        check("t4_flush_en_out", en_out, 1);
      end
      if (i == 16) check("t4_p16_en_out", en_out, 0);
    end
    pix(50, 50, 50, 50, 60, 0);
    check("t4_mode",   mode,   3);
    check("t4_runcnt", Runcnt, 5);

    // Near-flat context is regular when matching is exact.
    pix(50, 52, 49, 51, 48, 0);
    check("t5_mode",   mode,   0);
    check("t5_px",     Px,     52);
    check("t5_d1",     D1,     'h1FF);
    check("t5_d2",     D2,     3);
    check("t5_d3",     D3,     'h1FF);
    check("t5_en_out", en_out, 1);

    // Mid-run reset discards run_tmp=6; next run restarts at 1.
    for (int i = 0; i < 6; i++) pix(50, 50, 50, 50, 50, 0);
    reset = 1'b0;
    pix(50, 50, 50, 50, 50, 0);
    check("t6_rst_mode",   mode,   0);
    check("t6_rst_runcnt", Runcnt, 0);
    check("t6_rst_en_out", en_out, 0);
    check("t6_rst_ix_out", Ix_out, 0);
    check("t6_rst_px",     Px,     0);
    reset = 1'b1;
    pix(50, 50, 50, 50, 50, 0);
    check("t6_restart_en_out", en_out, 0);
    check("t6_restart_mode",   mode,   1);
    pix(50, 50, 50, 50, 60, 0);
    check("t6_intr_mode",   mode,   3);
    check("t6_intr_runcnt", Runcnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
